// File: rtl/library_fetch_if.sv
// Library read-back bus: the SRAM read port plus the downstream (x, y) stream.
// The engine is the master; the SRAM and the stream consumer sit on the slave side.
interface library_fetch_if;
   logic        o_mem_rd;
   logic [14:0] o_mem_addr;
   logic [9:0]  i_mem_data;
   logic        o_valid;
   logic [4:0]  o_x;
   logic [4:0]  o_y;
   logic        i_ready;

   modport master (
      output o_mem_rd, o_mem_addr, o_valid, o_x, o_y,
      input  i_mem_data, i_ready
   );

   modport slave (
      input  o_mem_rd, o_mem_addr, o_valid, o_x, o_y,
      output i_mem_data, i_ready
   );
endinterface

// File: rtl/library_fetch.sv
// Point-library read-back engine: walks the entries of one slot in order and
// streams the stored (x, y) pairs downstream. Reads go to a 1-cycle SRAM and
// land in a 2-entry FIFO; reads are throttled so that buffered data plus reads
// in flight never exceed the FIFO depth, so backpressure never drops a word.
module library_fetch #(
   parameter int NUM_SLOTS = 26
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [4:0]      i_slot,
   input  logic [10:0]     i_len,
   library_fetch_if.master bus,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err
);

   localparam logic [4:0]  LP_NUM_SLOTS = 5'(NUM_SLOTS);
   localparam logic [10:0] LP_MAX_LEN   = 11'd1024;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [4:0]  r_slot;
   logic [10:0] r_len;
   logic [9:0]  r_idx;
   logic [10:0] r_issued;
   logic [10:0] r_xfer_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic [9:0]  r_fifo [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_inflight;

   logic [10:0] w_len_clamped;
   logic        w_valid;
   logic        w_pop;
   logic [1:0]  w_occ;
   logic        w_issue;
   logic [9:0]  w_head;

   assign w_len_clamped = (i_len > LP_MAX_LEN) ? LP_MAX_LEN : i_len;
   assign w_valid       = (r_count != 2'd0);
   assign w_pop         = w_valid & bus.i_ready;
   // At most one read is ever in flight, so occupancy tops out at 2.
   assign w_occ         = r_count + {1'b0, r_inflight};
   // A pop in the same cycle frees the slot the new read will need.
   assign w_issue       = (r_state == S_FETCH) && (r_issued < r_len) &&
                          ((w_occ < 2'd2) || w_pop);
   assign w_head        = r_fifo[r_rd_ptr];

   assign bus.o_mem_rd   = w_issue;
   assign bus.o_mem_addr = w_issue ? {r_slot, r_idx} : 15'd0;
   assign bus.o_valid    = w_valid;
   assign bus.o_x        = w_valid ? w_head[9:5] : 5'd0;
   assign bus.o_y        = w_valid ? w_head[4:0] : 5'd0;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err          = r_err;

   // Control FSM: accepts requests, counts issued reads and transfers, registers status.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_slot     <= 5'd0;
         r_len      <= 11'd0;
         r_idx      <= 10'd0;
         r_issued   <= 11'd0;
         r_xfer_cnt <= 11'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees the pre-edge
         // counter values and later assignments in this block simply win.
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_issue) begin
            r_idx    <= r_idx + 10'd1;
            r_issued <= r_issued + 11'd1;
         end
         if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 11'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_slot >= LP_NUM_SLOTS) begin
                     r_err <= 1'b1;
                  end else if (w_len_clamped == 11'd0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_slot     <= i_slot;
                     r_len      <= w_len_clamped;
                     r_idx      <= 10'd0;
                     r_issued   <= 11'd0;
                     r_xfer_cnt <= 11'd0;
                     r_state    <= S_FETCH;
                     r_busy     <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (w_issue && (r_issued + 11'd1 == r_len)) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The final transfer necessarily empties the FIFO, so leaving on
               // that pop keeps done at len+3 cycles after the start edge.
               if (w_pop && (r_xfer_cnt + 11'd1 == r_len)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO bookkeeping: in-flight flag, pointers and occupancy; reset drops any pending SRAM word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight <= w_issue;
         if (r_inflight) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: captures the SRAM word one cycle after its read strobe.
   // NOTE: storage is deliberately not reset; the head is gated by o_valid,
   // so stale contents can never reach the outputs.
   always_ff @(posedge i_clk) begin
      if (r_inflight) begin
         r_fifo[r_wr_ptr] <= bus.i_mem_data;
      end
   end

endmodule

// File: tb/tb_library_fetch.sv
// Directed bench for library_fetch: a behavioural 1-cycle SRAM, a per-cycle
// observer and a linear sequence of scenarios with hand-derived expectations.
module tb_library_fetch;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic [4:0]  i_slot;
   logic [10:0] i_len;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   library_fetch_if bus ();

   library_fetch dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_slot  (i_slot),
      .i_len   (i_len),
      .bus     (bus),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   // Library SRAM: registered read, data valid the cycle after the strobe.
   logic [9:0] mem [0:32767];
   always @(posedge i_clk) begin
      if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
   end

   // Background fill: {x, y} = {slot, slot} ^ index, unique within a slot.
   function automatic logic [9:0] pat(input logic [14:0] a);
      return a[9:0] ^ {a[14:10], a[14:10]};
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   // Observer state, cleared at the start of each scenario.
   int          cyc_n;
   int          occ;
   int          occ_viol;
   int          hold_viol;
   int          zero_viol;
   int          n_done;
   int          n_err;
   int          n_busy;
   int          done_cyc;
   int          err_cyc;
   int          first_valid_cyc;
   int          first_rd_cyc;
   int          last_rd_cyc;
   logic        prev_stall;
   logic [4:0]  px;
   logic [4:0]  py;
   logic [14:0] rd_q [$];
   logic [9:0]  xf_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      cyc_n = 0; occ = 0; occ_viol = 0; hold_viol = 0; zero_viol = 0;
      n_done = 0; n_err = 0; n_busy = 0; done_cyc = -1; err_cyc = -1;
      first_valid_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
      prev_stall = 1'b0; px = 5'd0; py = 5'd0;
      rd_q.delete();
      xf_q.delete();
   endtask

   // One clock: drive inputs #1 after the edge, sample #2 after the edge.
   task automatic cyc(input logic rdy, input logic st = 1'b0);
      logic xfer;
      @(posedge i_clk);
      #1;
      bus.i_ready = rdy;
      i_start     = st;
      #1;
      cyc_n++;
      xfer = bus.o_valid && bus.i_ready;
      if (o_done) begin n_done++; done_cyc = cyc_n; end
      if (o_err)  begin n_err++;  err_cyc  = cyc_n; end
      if (o_busy) n_busy++;
      if (!bus.o_valid && (bus.o_x != 5'd0 || bus.o_y != 5'd0)) zero_viol++;
      if (!bus.o_mem_rd && bus.o_mem_addr != 15'd0) zero_viol++;
      if (prev_stall && (!bus.o_valid || bus.o_x != px || bus.o_y != py)) hold_viol++;
      if (bus.o_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
      if (bus.o_mem_rd) begin
         if (occ >= 2 && !xfer) occ_viol++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc_n;
         last_rd_cyc = cyc_n;
         rd_q.push_back(bus.o_mem_addr);
         occ++;
      end
      if (xfer) begin
         xf_q.push_back({bus.o_x, bus.o_y});
         occ--;
      end
      if (occ > 2) occ_viol++;
      prev_stall = bus.o_valid && !bus.i_ready;
      px = bus.o_x;
      py = bus.o_y;
   endtask

   task automatic start(input logic [4:0] slot, input logic [10:0] len);
      clear();
      i_slot  = slot;
      i_len   = len;
      i_start = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      logic [9:0] slot3 [4];
      slot3[0] = {5'd1, 5'd2};
      slot3[1] = {5'd3, 5'd4};
      slot3[2] = {5'd5, 5'd6};
      slot3[3] = {5'd7, 5'd8};
      for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
      for (int i = 0; i < 4; i++) mem[15'h0C00 + 15'(i)] = slot3[i];

      i_rst_n = 1'b0; i_start = 1'b0; i_slot = 5'd0; i_len = 11'd0;
      bus.i_ready = 1'b0;
      bus.i_mem_data = 10'd0;
      clear();

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_mem_rd", 32'(bus.o_mem_rd), 32'd0);
      check("rst_addr",   32'(bus.o_mem_addr), 32'd0);
      check("rst_valid",  32'(bus.o_valid), 32'd0);
      check("rst_xy",     32'({bus.o_x, bus.o_y}), 32'd0);
      check("rst_status", 32'({o_busy, o_done, o_err}), 32'd0);
      #2 i_rst_n = 1'b1;
      cyc(1'b0);

      // Slot 3, len 4, no backpressure
      start(5'd3, 11'd4);
      repeat (8) cyc(1'b1);
      check("s3_rd_count", 32'(rd_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("s3_addr", 32'(rd_q[i]), 32'h0C00 + 32'(i));
      check("s3_first_rd_cyc", 32'(first_rd_cyc), 32'd1);
      check("s3_last_rd_cyc",  32'(last_rd_cyc), 32'd4);
      check("s3_first_valid",  32'(first_valid_cyc), 32'd3);
      check("s3_xfer_count",   32'(xf_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("s3_pair", 32'(xf_q[i]), 32'(slot3[i]));
      check("s3_done_count", 32'(n_done), 32'd1);
      check("s3_done_cyc",   32'(done_cyc), 32'd7);
      check("s3_busy_cycles", 32'(n_busy), 32'd7);
      check("s3_zero_gating", 32'(zero_viol), 32'd0);

      // Slot 25, len 1500 clamps to 1024; starts on the IDLE cycle after the last run
      start(5'd25, 11'd1500);
      repeat (1030) cyc(1'b1);
      check("s25_rd_count", 32'(rd_q.size()), 32'd1024);
      check("s25_first_addr", 32'(rd_q[0]), 32'h6400);
      check("s25_last_addr",  32'(rd_q[1023]), 32'h67FF);
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] == 15'h6800) bad++;
      check("s25_no_0x6800", 32'(bad), 32'd0);
      check("s25_xfer_count", 32'(xf_q.size()), 32'd1024);
      bad = 0;
      foreach (xf_q[i]) if (xf_q[i] !== (10'(i) ^ 10'h339)) bad++;
      check("s25_pairs_ordered", 32'(bad), 32'd0);
      check("s25_done_count", 32'(n_done), 32'd1);
      check("s25_done_cyc",   32'(done_cyc), 32'd1027);

      // Slot 7, len 6, stall after first valid then toggling ready
      start(5'd7, 11'd6);
      repeat (7) cyc(1'b0);
      check("s7_first_valid", 32'(first_valid_cyc), 32'd3);
      check("s7_reads_while_stalled", 32'(rd_q.size()), 32'd2);
      check("s7_no_xfer_while_stalled", 32'(xf_q.size()), 32'd0);
      for (int i = 0; i < 24; i++) cyc((i % 2) == 0);
      check("s7_occ_rule", 32'(occ_viol), 32'd0);
      check("s7_hold_stable", 32'(hold_viol), 32'd0);
      check("s7_rd_count", 32'(rd_q.size()), 32'd6);
      check("s7_xfer_count", 32'(xf_q.size()), 32'd6);
      bad = 0;
      foreach (xf_q[i]) if (xf_q[i] !== (10'(i) ^ 10'h0E7)) bad++;
      check("s7_pairs_ordered", 32'(bad), 32'd0);
      check("s7_done_count", 32'(n_done), 32'd1);

      // Out-of-range slot is rejected
      start(5'd26, 11'd5);
      repeat (3) cyc(1'b1);
      check("err_count", 32'(n_err), 32'd1);
      check("err_cyc", 32'(err_cyc), 32'd1);
      check("err_busy", 32'(n_busy), 32'd0);
      check("err_reads", 32'(rd_q.size()), 32'd0);
      check("err_done", 32'(n_done), 32'd0);

      // Zero-length request completes immediately
      start(5'd5, 11'd0);
      repeat (3) cyc(1'b1);
      check("len0_done_count", 32'(n_done), 32'd1);
      check("len0_done_cyc", 32'(done_cyc), 32'd1);
      check("len0_busy", 32'(n_busy), 32'd1);
      check("len0_reads", 32'(rd_q.size()), 32'd0);
      check("len0_err", 32'(n_err), 32'd0);

      // Slot 1, len 10, asynchronous reset after the 4th transfer
      start(5'd1, 11'd10);
      for (int g = 0; g < 20 && xf_q.size() < 4; g++) cyc(1'b1);
      check("rst_run_reached_4", 32'(xf_q.size()), 32'd4);
      @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      check("arst_mem_rd", 32'(bus.o_mem_rd), 32'd0);
      check("arst_addr",   32'(bus.o_mem_addr), 32'd0);
      check("arst_valid",  32'(bus.o_valid), 32'd0);
      check("arst_xy",     32'({bus.o_x, bus.o_y}), 32'd0);
      check("arst_status", 32'({o_busy, o_done, o_err}), 32'd0);
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      clear();
      repeat (3) cyc(1'b1);
      check("arst_stale_ignored", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      check("arst_idle_busy", 32'(n_busy), 32'd0);
      start(5'd2, 11'd2);
      repeat (7) cyc(1'b1);
      check("s2_xfer_count", 32'(xf_q.size()), 32'd2);
      check("s2_pair0", 32'(xf_q[0]), 32'h042);
      check("s2_pair1", 32'(xf_q[1]), 32'h043);
      check("s2_done_cyc", 32'(done_cyc), 32'd5);

      // Slot 4, len 5, with a stray start for slot 9 during FETCH
      start(5'd4, 11'd5);
      cyc(1'b1);
      i_slot = 5'd9;
      i_len  = 11'd3;
      cyc(1'b1, 1'b1);
      repeat (8) cyc(1'b1);
      check("s4_rd_count", 32'(rd_q.size()), 32'd5);
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] !== (15'h1000 + 15'(i))) bad++;
      check("s4_addrs", 32'(bad), 32'd0);
      check("s4_xfer_count", 32'(xf_q.size()), 32'd5);
      bad = 0;
      foreach (xf_q[i]) if (xf_q[i] !== (10'(i) ^ 10'h084)) bad++;
      check("s4_pairs_ordered", 32'(bad), 32'd0);
      check("s4_done_count", 32'(n_done), 32'd1);
      check("s4_done_cyc", 32'(done_cyc), 32'd8);
      check("s4_no_err", 32'(n_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/library_fetch.md
# library_fetch

Read-back engine for the point library. For a selected slot, it walks the stored entries in order and streams each (x, y) pair downstream with a valid/ready handshake. It sits between the shared library SRAM (1-cycle registered read) and the matching/drawing logic, and it is the read side of the library store path. Slot s, entry k lives at SRAM address {s[4:0], k[9:0]}, with data word {x[4:0], y[4:0]}.

## Interface
- NUM_SLOTS, 26, number of valid slots; slot indices 0..NUM_SLOTS-1.
- SLOT_DEPTH, 1024, entries per slot; index width is 10 bits.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request a fetch; sampled only in IDLE.
- i_slot  in  5  slot to read; sampled with i_start.
- i_len  in  11  number of entries to read (0..1024); values above 1024 are clamped to 1024; sampled with i_start.
- o_mem_rd  out  1  SRAM read strobe.
- o_mem_addr  out  15  SRAM address {slot, index}; 0 when o_mem_rd=0.
- i_mem_data  in  10  {x, y}; valid exactly 1 cycle after o_mem_rd.
- o_valid  out  1  output pair valid.
- o_x  out  5  x coordinate; 0 when o_valid=0.
- o_y  out  5  y coordinate; 0 when o_valid=0.
- i_ready  in  1  downstream accepts; a transfer occurs when o_valid and i_ready are both 1.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  1-cycle pulse after the last pair is transferred, or immediately for len=0.
- o_err  out  1  1-cycle pulse when i_start is rejected because i_slot >= NUM_SLOTS.

## Operation
- **States:**
  - IDLE: waits for i_start.
  - FETCH: reads are being issued.
  - DRAIN: all reads issued; waits for the buffer to empty.
  - DONE: 1 cycle, o_done=1.
- **IDLE transitions:**
  - i_start with i_slot >= NUM_SLOTS: o_err pulses next cycle; state stays IDLE; nothing is latched.
  - i_start with len=0: go to DONE.
  - Otherwise: latch slot and len, clear the read index and the transferred count, go to FETCH.
- **Buffering:**
  - Data is held in a 2-entry FIFO.
  - occ = entries buffered + reads in flight (0..2).
  - A read is issued in FETCH when issued < len and either occ < 2, or occ == 2 and a transfer happens this cycle.
  - On each issue, the index increments.
  - When issued reaches len, go to DRAIN.
- **Output:**
  - The output is the FIFO head: o_valid = FIFO not empty.
  - While o_valid=1 and i_ready=0, o_x and o_y are held stable.
- **Completion:** DRAIN moves to DONE when transferred == len and the FIFO is empty. DONE then returns to IDLE.
- **Ignored inputs:**
  - i_start is ignored outside IDLE.
  - i_slot and i_len are ignored except when sampled with an accepted i_start.
- **Arithmetic:**
  - Index: 10 bits, issued count: 11 bits; the index never wraps because issued ≤ 1024. For len=1024, the last address is {slot, 10'h3FF}.
  - Transferred count: 11 bits; compared against the clamped len.
- **Reset:**
  - Asynchronous reset at any time aborts the fetch.
  - Reset clears the FIFO, counters and in-flight tracking; all outputs become 0.
  - The SRAM response to a read issued before reset is discarded.

## Timing
- **Reset values:** every output is 0 and state = IDLE.
- **Start:** i_start is sampled at edge 0. FETCH is active in the following cycle, with o_mem_rd=1 and o_mem_addr={slot, 0}.
- **Read latency:** data returns in the next cycle and is written into the FIFO at that edge. The first o_valid therefore appears 2 cycles after the first o_mem_rd; start-to-first-valid is 3 edges.
- **Throughput:** with i_ready held at 1, one read is issued and one pair is transferred per cycle. len=N completes with o_done asserted N+3 cycles after the start edge.
- **Backpressure:**
  - While i_ready=0, at most 2 reads are outstanding or buffered, and o_mem_rd drops to 0.
  - Issuing resumes in the same cycle that i_ready rises and a transfer occurs.
  - No data is lost or duplicated.
- **Simultaneous push and pop** on the FIFO in the same cycle: legal; occupancy is unchanged.
- **Back-to-back runs:** a new i_start is accepted on the IDLE cycle after DONE.

## Test plan
- Slot 3, len=4, SRAM preloaded with {x,y} = {1,2},{3,4},{5,6},{7,8}, i_ready=1:
  - addresses 0x0C00–0x0C03 are issued on consecutive cycles;
  - 4 pairs appear in order;
  - o_done pulses once at cycle 7.
- Slot 25, len=1500 (clamped to 1024), i_ready=1:
  - 1024 reads ending at address 0x67FF, no read at 0x6800;
  - 1024 transfers, then o_done.
- Slot 7, len=6, i_ready=0 for 5 cycles after the first valid, then toggling 1/0:
  - o_mem_rd is never asserted with occ=2 unless a pop occurs;
  - o_x and o_y stay stable while stalled;
  - exactly 6 ordered pairs are transferred.
- i_start with slot=26 → o_err pulses, o_busy stays 0, no reads. i_start with len=0 → o_done pulses 1 cycle later, no reads.
- Slot 1, len=10: deassert i_rst_n asynchronously after the 4th transfer:
  - all outputs read 0 immediately;
  - the stale SRAM word is ignored;
  - a fresh start on slot 2, len=2 streams the correct 2 pairs.
- Assert i_start with slot 9 during FETCH of slot 4: ignored; the slot 4 sequence completes intact.
